cgr_count: RTL

Histogram accumulator directly downstream of the CGR address generator. Each cycle it samples the generator's 6-bit cell address and write strobe and increments the matching bin in a 64-entry count memory. The memory is a read-modify-write pipeline with hazard forwarding. On request the block streams all 64 bins out over a valid/ready port to the feature/matching stage. It also self-clears after reset and on command.

---
 rtl/cgr_count_if.sv | 30 +++
 rtl/cgr_count.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cgr_count_if.sv
// Bus bundle for cgr_count: generator strobe and commands in, histogram bin stream out.
// Handshake: a beat transfers on a rising CLK edge where dout_valid & dout_ready are both
// high; while dout_valid is high and dout_ready low, dout_data/dout_bin/dout_last hold.
interface cgr_count_if #(
    parameter int COUNT_W = 16
);
    logic [5:0]         addr;
    logic               wen_cgr;
    logic               clear_start;
    logic               dump_start;
    logic [COUNT_W-1:0] dout_data;
    logic [5:0]         dout_bin;
    logic               dout_valid;
    logic               dout_ready;
    logic               dout_last;
    logic               busy;
    logic               sat_flag;
    logic               drop_flag;
    logic [1:0]         state_dbg;

    modport master (
        output addr, wen_cgr, clear_start, dump_start, dout_ready,
        input  dout_data, dout_bin, dout_valid, dout_last, busy, sat_flag, drop_flag, state_dbg
    );

    modport slave (
        input  addr, wen_cgr, clear_start, dump_start, dout_ready,
        output dout_data, dout_bin, dout_valid, dout_last, busy, sat_flag, drop_flag, state_dbg
    );
endinterface

// File: rtl/cgr_count.sv
// CGR histogram: 64-bin read-modify-write counter with forwarding, self-clear and bin dump.
// Optional macro CGR_COUNT_SAT_EN makes bins saturate instead of wrapping.
module cgr_count #(
    parameter int COUNT_W = 16,
    parameter int SKIP    = 3
) (
    input  logic        CLK,
    input  logic        RST,
    cgr_count_if.slave  bus
);
    localparam int SKW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);

    typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_DUMP} state_t;

    state_t             r_state;
    logic [5:0]         r_clr_idx;
    logic [SKW-1:0]     r_skip;
    logic               r_s1_valid;
    logic [5:0]         r_s1_addr;
    logic [COUNT_W-1:0] r_s1_data;
    logic [COUNT_W-1:0] r_mem [64];
    logic               r_dout_valid;
    logic               r_dout_last;
    logic [5:0]         r_dout_bin;
    logic [COUNT_W-1:0] r_dout_data;
    logic               r_busy;
    logic               r_sat;
    logic               r_drop;

    logic [COUNT_W-1:0] w_inc;
    logic               w_sat_hit;
    logic               w_skip_done;
    logic               w_count;
    logic [COUNT_W-1:0] w_s1_rd;
    logic [5:0]         w_next_bin;
    logic [5:0]         w_dump_idx;
    logic [COUNT_W-1:0] w_dump_rd;

    // Stage-2 result; the same value is forwarded to any read of the bin being written.
    always_comb begin
        w_inc     = r_s1_data + COUNT_W'(1);
        w_sat_hit = 1'b0;
`ifdef CGR_COUNT_SAT_EN
        if (&r_s1_data) begin
            w_inc     = r_s1_data;
            w_sat_hit = 1'b1;
        end
`endif
    end

    always_comb begin
        w_skip_done = (r_skip == SKW'(SKIP));
        w_count     = (r_state == S_ACCUM) && bus.wen_cgr && w_skip_done;
        w_s1_rd     = (r_s1_valid && (r_s1_addr == bus.addr)) ? w_inc : r_mem[bus.addr];
        w_next_bin  = r_dout_bin + 6'd1;
        w_dump_idx  = (r_state == S_DRAIN) ? 6'd0 : w_next_bin;
        w_dump_rd   = (r_s1_valid && (r_s1_addr == w_dump_idx)) ? w_inc : r_mem[w_dump_idx];
    end

    // A write still in flight when a clear starts is dropped; that bin is zeroed anyway.
    always_ff @(posedge CLK) begin
        if (r_state == S_CLEAR)
            r_mem[r_clr_idx] <= '0;
        else if (r_s1_valid)
            r_mem[r_s1_addr] <= w_inc;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_CLEAR;
            r_clr_idx    <= 6'd0;
            r_skip       <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_addr    <= 6'd0;
            r_s1_data    <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_dout_bin   <= 6'd0;
            r_dout_data  <= '0;
            r_busy       <= 1'b1;
            r_sat        <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_s1_valid <= w_count;
            r_s1_addr  <= bus.addr;
            r_s1_data  <= w_s1_rd;
            if ((r_state != S_ACCUM) && bus.wen_cgr)
                r_drop <= 1'b1;
            if (w_sat_hit && r_s1_valid && (r_state != S_CLEAR))
                r_sat <= 1'b1;

            case (r_state)
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 6'd1;
                    if (r_clr_idx == 6'd63) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b0;
                        r_skip  <= '0;
                        r_sat   <= 1'b0;
                        r_drop  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (bus.wen_cgr && !w_skip_done)
                        r_skip <= r_skip + SKW'(1);
                    if (bus.clear_start) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= 6'd0;
                        r_busy    <= 1'b1;
                    end else if (bus.dump_start) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state      <= S_DUMP;
                    r_dout_valid <= 1'b1;
                    r_dout_bin   <= 6'd0;
                    r_dout_last  <= 1'b0;
                    r_dout_data  <= w_dump_rd;
                end
                S_DUMP: begin
                    if (r_dout_valid && bus.dout_ready) begin
                        if (r_dout_last) begin
                            r_dout_valid <= 1'b0;
                            r_dout_last  <= 1'b0;
                            r_state      <= S_ACCUM;
                            r_busy       <= 1'b0;
                        end else begin
                            r_dout_bin  <= w_next_bin;
                            r_dout_data <= w_dump_rd;
                            r_dout_last <= (w_next_bin == 6'd63);
                        end
                    end
                end
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_idx <= 6'd0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dout_data  = r_dout_data;
    assign bus.dout_bin   = r_dout_bin;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_last  = r_dout_last;
    assign bus.busy       = r_busy;
    assign bus.sat_flag   = r_sat;
    assign bus.drop_flag  = r_drop;
    assign bus.state_dbg  = r_state;
endmodule
